uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_fifo.sv | 84 ++++++++
 rtl/uart_tx_fifo.sv | 100 ++++++++++
 tb/tb_uart_tx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: drain-state encoding and default depth.
package uart_pkg;

    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_BUSY = 2'd2
    } drain_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with registered full/empty/level; storage itself is never reset.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr,
    input  logic [7:0]    wdata,
    input  logic          rd,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          wr_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_n;
    logic          full_q;
    logic          empty_q;
    logic          push;
    logic          pop;

    // full is the pre-edge flag, so a write while full is rejected even if a pop frees a slot
    assign push    = wr && !full_q && !flush;
    assign pop     = rd && !empty_q && !flush;
    assign wr_drop = wr && full_q && !flush;

    always_comb begin
        level_n = level_q;
        if (push && !pop) begin
            level_n = level_q + LW'(1);
        end else if (pop && !push) begin
            level_n = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            level_q <= level_n;
            full_q  <= (level_n == LW'(DEPTH));
            empty_q <= (level_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

    assign rdata = mem[rptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO plus drain FSM that hands one byte at a time to a UART transmitter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [7:0]    wdata,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          ovf,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_rdy
);

    drain_state_t state_q;
    drain_state_t state_n;
    logic         pop;
    logic         start_n;
    logic [7:0]   head;
    logic         wr_drop;
    logic         ovf_q;
    logic         tx_start_q;
    logic [7:0]   tx_data_q;

    uart_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr      (wr),
        .wdata   (wdata),
        .rd      (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .wr_drop (wr_drop)
    );

    // No new byte is launched in a flush cycle; a transfer already under way runs to completion
    always_comb begin
        state_n = state_q;
        pop     = 1'b0;
        start_n = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && tx_rdy && !flush) begin
                    pop     = 1'b1;
                    start_n = 1'b1;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                state_n = ST_BUSY;
            end
            ST_BUSY: begin
                if (tx_rdy) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            tx_start_q <= start_n;
            if (pop) begin
                tx_data_q <= head;
            end
            if (flush) begin
                ovf_q <= 1'b0;
            end else if (wr_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ovf      = ovf_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences, random vs. queue model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr = 1'b0;
    logic [7:0]    wdata = 8'h00;
    logic          flush = 1'b0;
    logic          tx_rdy = 1'b0;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          ovf;
    logic          tx_start;
    logic [7:0]    tx_data;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .wdata    (wdata),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_rdy   (tx_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] wdata;
        logic       flush;
        logic       rdy;
        int         lvl;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       start;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic w, input logic [7:0] d, input logic f, input logic r,
                                input int l, input logic fu, input logic em, input logic ov,
                                input logic st, input logic [7:0] da);
        vec_t v;
        v.wr = w; v.wdata = d; v.flush = f; v.rdy = r;
        v.lvl = l; v.full = fu; v.empty = em; v.ovf = ov; v.start = st; v.data = da;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int l, input logic fu, input logic em,
                           input logic ov, input logic st, input logic [7:0] da);
        chk({tag, ".level"}, 32'(level), 32'(l));
        chk({tag, ".full"}, 32'(full), 32'(fu));
        chk({tag, ".empty"}, 32'(empty), 32'(em));
        chk({tag, ".ovf"}, 32'(ovf), 32'(ov));
        chk({tag, ".tx_start"}, 32'(tx_start), 32'(st));
        chk({tag, ".tx_data"}, 32'(tx_data), 32'(da));
    endtask

    // Drive inputs, let one rising edge pass, then sample 1 time unit later
    task automatic cyc(input logic w, input logic [7:0] d, input logic f, input logic r);
        wr = w; wdata = d; flush = f; tx_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; wr = 1'b0; flush = 1'b0; tx_rdy = 1'b0; wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_all(tag, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
    endtask

    // Reference model state
    logic [7:0] q [$];
    logic       m_ovf;
    logic       m_start;
    logic [7:0] m_data;
    int         m_eng;

    initial begin
        int nstart;
        int busy;
        logic rdy_now;
        logic [7:0] exp3 [3];
        int bias;

        for (int i = 0; i < 16; i++)
            tbl[i] = mk(1'b1, 8'(i), 1'b0, 1'b0, i + 1, (i == 15), 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[16] = mk(1'b1, 8'h10, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tbl[18] = mk(1'b1, 8'h11, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        tbl[19] = mk(1'b1, 8'h20, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tbl[20] = mk(1'b1, 8'h30, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tbl[21] = mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tbl[22] = mk(1'b1, 8'h55, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[23] = mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
        tbl[24] = mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
        tbl[25] = mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55);

        // Vector table: fill, overflow, pop-vs-full-write, flush, single-byte latency
        do_reset("reset0");
        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].wr, tbl[i].wdata, tbl[i].flush, tbl[i].rdy);
            chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].full, tbl[i].empty,
                    tbl[i].ovf, tbl[i].start, tbl[i].data);
        end

        // Flush while the drain FSM waits on the transmitter
        do_reset("reset1");
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk_all("flush.launch", 5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush.busy_level", 32'(level), 32'd5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk_all("flush.after", 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0);
        nstart = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 8'h00, 1'b0, (k >= 3));
            if (tx_start) nstart++;
        end
        chk("flush.no_more_starts", 32'(nstart), 32'd0);
        chk("flush.data_held", 32'(tx_data), 32'hC0);

        // Reset asserted while tx_start is high
        do_reset("reset2");
        cyc(1'b1, 8'h71, 1'b0, 1'b1);
        cyc(1'b1, 8'h72, 1'b0, 1'b1);
        chk("rstsend.start", 32'(tx_start), 32'd1);
        chk("rstsend.level", 32'(level), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("rstsend.async", 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        nstart = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
            if (tx_start) nstart++;
        end
        chk("rstsend.no_start", 32'(nstart), 32'd0);
        cyc(1'b1, 8'h73, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rstsend.idle_start", 32'(tx_start), 32'd1);
        chk("rstsend.idle_data", 32'(tx_data), 32'h73);

        // Three bytes through a transmitter that stays busy 10 cycles per byte
        do_reset("reset3");
        exp3[0] = 8'hA1; exp3[1] = 8'hA2; exp3[2] = 8'hA3;
        nstart = 0;
        busy = 0;
        for (int c = 0; c < 200 && nstart < 3; c++) begin
            rdy_now = (busy == 0);
            cyc(c < 3, (c < 3) ? exp3[c] : 8'h00, 1'b0, rdy_now);
            if (busy > 0) busy--;
            if (tx_start) begin
                chk($sformatf("xmit.data%0d", nstart), 32'(tx_data), 32'(exp3[nstart]));
                chk($sformatf("xmit.rdy%0d", nstart), 32'(rdy_now), 32'd1);
                nstart++;
                busy = 10;
            end
        end
        chk("xmit.count", 32'(nstart), 32'd3);

        // Random traffic against the queue model
        do_reset("reset4");
        q.delete();
        m_ovf = 1'b0; m_start = 1'b0; m_data = 8'h00; m_eng = 0;
        bias = 2;
        for (int n = 0; n < 3000; n++) begin
            logic w, f, r, full_pre, can_pop;
            logic [7:0] d;
            if (n % 250 == 0) bias = $urandom_range(0, 4);
            w = ($urandom_range(0, 99) < 60);
            f = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 3) < bias);
            d = 8'($urandom);

            full_pre = (q.size() == DEPTH);
            can_pop  = (m_eng == 0) && (q.size() != 0) && r && !f;
            m_start  = 1'b0;
            if (f) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (can_pop) m_data = q.pop_front();
                if (w) begin
                    if (full_pre) m_ovf = 1'b1;
                    else q.push_back(d);
                end
            end
            // Transmit handshake: launch, one pulse cycle, then wait for the transmitter
            case (m_eng)
                0: if (can_pop) begin m_eng = 1; m_start = 1'b1; end
                1: m_eng = 2;
                default: if (r) m_eng = 0;
            endcase

            cyc(w, d, f, r);
            chk($sformatf("rand%0d", n),
                {15'd0, level, full, empty, ovf, tx_start, tx_data},
                {15'd0, LW'(q.size()), (q.size() == DEPTH), (q.size() == 0), m_ovf, m_start, m_data});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
